// File: rtl/dram_access_ctrl.sv
// Single-outstanding requester for the two-phase DRAM pin interface.
// Optional last-write forwarding is enabled with `define LAST_WRITE_FWD_EN.
module dram_access_ctrl #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int HOLD_CYC = 2,
  parameter int RD_LAT   = 3
) (
  input  logic          Clk,
  input  logic          nRst,
  input  logic          ReqValid,
  output logic          ReqReady,
  input  logic          ReqWr,
  input  logic [AW-1:0] ReqAddr,
  input  logic [DW-1:0] ReqWData,
  output logic          RspValid,
  output logic [DW-1:0] RspData,
  output logic          Busy,
  output logic [AW-1:0] MemAddr,
  output logic          MemRD,
  output logic          MemWR,
  output logic [DW-1:0] MemDataIn,
  input  logic [DW-1:0] MemDataOut
);

  localparam int         RD_EFF    = (RD_LAT > HOLD_CYC) ? RD_LAT : HOLD_CYC;
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);
  localparam logic [7:0] RD_LAST   = 8'(RD_EFF - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_RECOVER
  } state_t;

  state_t        state, state_nxt;
  logic          op;
  logic [7:0]    cnt;
  logic          accept;
  logic          capture;
  logic          fwd_hit;
  logic          fwd;
  logic [DW-1:0] fwd_data;

`ifdef LAST_WRITE_FWD_EN
  logic          lw_vld;
  logic [AW-1:0] lw_addr;
  logic [DW-1:0] lw_data;

  assign fwd_hit  = !ReqWr && lw_vld && (ReqAddr == lw_addr);
  assign fwd_data = lw_data;

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      lw_vld  <= 1'b0;
      lw_addr <= '0;
      lw_data <= '0;
      fwd     <= 1'b0;
    end else if (accept) begin
      fwd <= fwd_hit;
      if (ReqWr) begin
        lw_vld  <= 1'b1;
        lw_addr <= ReqAddr;
        lw_data <= ReqWData;
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd      = 1'b0;
  assign fwd_data = '0;
`endif

  assign accept   = ReqValid && (state == S_IDLE);
  assign ReqReady = (state == S_IDLE);
  assign Busy     = (state != S_IDLE);
  assign RspValid = (state == S_RESP);
  assign MemRD    = (state == S_ISSUE) && !op;
  assign MemWR    = (state == S_ISSUE) && op;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      S_IDLE:
        if (accept) state_nxt = fwd_hit ? S_RESP : S_ISSUE;
      S_ISSUE:
        if (cnt == HOLD_LAST) begin
          if (op) begin
            state_nxt = S_RESP;
          end else if (RD_EFF == HOLD_CYC) begin
            capture   = 1'b1;
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      S_WAIT:
        if (cnt == RD_LAST) begin
          capture   = 1'b1;
          state_nxt = S_RESP;
        end
      // a forwarded read has no DRAM strobes to let settle, so skip RECOVER
      S_RESP:    state_nxt = fwd ? S_IDLE : S_RECOVER;
      S_RECOVER: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state     <= S_IDLE;
      op        <= 1'b0;
      cnt       <= '0;
      MemAddr   <= '0;
      MemDataIn <= '0;
      RspData   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op  <= ReqWr;
        cnt <= '0;
        if (fwd_hit) begin
          RspData <= fwd_data;
        end else begin
          MemAddr <= ReqAddr;
          if (ReqWr) MemDataIn <= ReqWData;
        end
      end else if (state == S_ISSUE || state == S_WAIT) begin
        cnt <= cnt + 8'd1;
      end
      if (capture) RspData <= MemDataOut;
    end
  end

endmodule

// File: doc/dram_access_ctrl.md
Name: dram_access_ctrl

Overview:
- Single-clock requester that drives the two-phase DRAM model's pin interface: address, RD, WR, write data, read data.
- Accepts one read or write at a time from a CPU-side valid/ready port.
- Holds the DRAM strobes stable long enough for both DRAM phase clocks to sample them, captures read data after a fixed latency, and returns a one-cycle response pulse.
- Sits between the pipeline's memory stage and the data memory instance.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- HOLD_CYC, 2, cycles the strobes, address and write data are held asserted; legal range 1..255.
- RD_LAT, 3, cycles from the first strobe cycle to read-data capture, inclusive; effective value is max(RD_LAT, HOLD_CYC); max 255.

Ports:
- Clk, input, 1, system clock; all state updates on posedge.
- nRst, input, 1, asynchronous active-low reset.
- ReqValid, input, 1, CPU request present.
- ReqReady, output, 1, controller can accept a request this cycle.
- ReqWr, input, 1, 1 = write, 0 = read; sampled on accept.
- ReqAddr, input, AW, request address; sampled on accept.
- ReqWData, input, DW, write data; sampled on accept.
- RspValid, output, 1, one-cycle completion pulse for both reads and writes.
- RspData, output, DW, read data; holds its value until the next read completes.
- Busy, output, 1, high in every state other than IDLE.
- MemAddr, output, AW, to DRAM Addr.
- MemRD, output, 1, to DRAM RD.
- MemWR, output, 1, to DRAM WR.
- MemDataIn, output, DW, to DRAM DataIn.
- MemDataOut, input, DW, from DRAM DataOut.

Behaviour:
- Reset (nRst low, asynchronous):
  - State goes to IDLE; counter cleared.
  - All outputs driven to 0 except ReqReady, which is 1.
  - A reset asserted mid-transaction abandons it: no RspValid, strobes drop immediately.
- States:
  - IDLE: ReqReady = 1.
    - ReqValid && ReqReady at a posedge = accept. Latch ReqWr into an internal op register; load MemAddr from ReqAddr; for a write, load MemDataIn from ReqWData.
    - Clear the counter and go to ISSUE.
  - ISSUE: MemRD = ~op, MemWR = op. The counter increments each cycle.
    - After HOLD_CYC cycles: a write goes to RESP; a read goes to WAIT, or directly to capture if effective RD_LAT == HOLD_CYC.
  - WAIT (reads only): strobes low; the counter continues.
    - At the end of cycle number effective RD_LAT (counting the first ISSUE cycle as 1), register RspData <= MemDataOut and go to RESP.
  - RESP: RspValid = 1 for exactly one cycle; strobes low. Next state is RECOVER.
  - RECOVER: one idle cycle with strobes low so the DRAM's latched RD/WR clear. Next state is IDLE.
- ReqReady is 0 in every state except IDLE. Requests are not queued; ReqValid seen in other states is ignored.
- MemAddr and MemDataIn keep their last values after a transaction. RspData is unchanged by writes.
- MemRD and MemWR are never high together.
- Latency with defaults (accept at edge 0):
  - Read: ISSUE in cycles 1-2, WAIT in cycle 3, RspValid in cycle 4, RECOVER in cycle 5, ReqReady in cycle 6.
  - Write: ISSUE in cycles 1-2, RspValid in cycle 3, RECOVER in cycle 4, ReqReady in cycle 5.
- Counter: 8 bits; it never wraps within legal parameter values.

Optional Feature:
- Macro: LAST_WRITE_FWD_EN.
- Defined:
  - Add a last-write register (address, data, valid bit). Valid is cleared on reset and set on every accepted write.
  - An accepted read whose ReqAddr equals the last-write address while valid = 1 makes no DRAM access: MemRD stays 0 and MemAddr is unchanged.
  - RspData = last-write data and RspValid = 1 in cycle 1 after accept; ReqReady returns in cycle 2 (RECOVER is skipped).
- Undefined: all reads access the DRAM; there is no extra state.

Test Plan:
- Reset: hold nRst=0 mid-ISSUE of a write -> MemWR, RspValid and Busy drop to 0 asynchronously; ReqReady=1 after release; no response is issued.
- Write: addr 0x0005, data 0xBEEF, defaults -> MemWR=1 in cycles 1-2 with MemAddr=0x0005 and MemDataIn=0xBEEF; RspValid in cycle 3; ReqReady in cycle 5.
- Read-back against the DRAM model: read 0x0005 -> MemRD=1 in cycles 1-2; RspData=0xBEEF with RspValid in cycle 4; ReqReady in cycle 6.
- Back-to-back requests: ReqValid held high with three queued requests -> each accepted only when ReqReady=1; MemRD and MemWR never overlap; RspValid count = 3.
- Parameters HOLD_CYC=3, RD_LAT=1 -> effective latency 3; the read's RspValid arrives in cycle 4.
- With LAST_WRITE_FWD_EN: write 0x0007 = 0x1234, then read 0x0007 -> MemRD stays 0, RspData=0x1234 in cycle 1; a read of 0x0008 goes to the DRAM.
